// File: rtl/uart_matrix_parser_if.sv
// Byte-in / matrix-out bundle between the UART receive path, the matrix parser and matrix storage.
// The master side supplies bytes and the mode enable; the slave side (the parser) returns matrices and status.
interface uart_matrix_parser_if #(
   parameter int MAX_DIM = 5,
   parameter int ELEM_W  = 8
);
   logic                              en;
   logic                              uart_rx_done;
   logic [7:0]                        uart_rx_data;
   logic                              write_en;
   logic [2:0]                        mat_row;
   logic [2:0]                        mat_col;
   logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] data_flow;
   logic                              busy;
   logic                              err;
   logic [1:0]                        err_code;

   modport master (
      output en, uart_rx_done, uart_rx_data,
      input  write_en, mat_row, mat_col, data_flow, busy, err, err_code
   );

   modport slave (
      input  en, uart_rx_done, uart_rx_data,
      output write_en, mat_row, mat_col, data_flow, busy, err, err_code
   );
endinterface

// File: rtl/uart_matrix_parser.sv
// Parses an ASCII stream of decimal tokens (rows, cols, then row-major elements) into a complete
// matrix and presents it to storage with a single write_en pulse.
module uart_matrix_parser #(
   parameter int MAX_DIM = 5,
   parameter int ELEM_W  = 8
) (
   input logic                 clk,
   input logic                 rst,
   uart_matrix_parser_if.slave bus
);
   localparam int N_SLOTS = MAX_DIM * MAX_DIM;
   localparam int DF_W    = N_SLOTS * ELEM_W;
   localparam int ACC_W   = ELEM_W + 4;
   localparam int MUL_W   = ACC_W + 4;
   localparam int CNT_W   = 6;
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0] ELEM_MAX = {{4{1'b0}}, {ELEM_W{1'b1}}};
   localparam logic [ACC_W-1:0] DIM_MAX  = ACC_W'(MAX_DIM);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ROW,
      ST_GET_COL,
      ST_GET_ELEM,
      ST_ERR_SYNC
   } state_t;

   state_t            state_reg, state_next;
   logic [ACC_W-1:0]  acc_reg, acc_next;
   logic              pend_reg, pend_next;
   logic [2:0]        rows_reg, rows_next;
   logic [2:0]        cols_reg, cols_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DF_W-1:0]   stage_reg, stage_next;
   logic              write_en_reg, write_en_next;
   logic [2:0]        mat_row_reg, mat_row_next;
   logic [2:0]        mat_col_reg, mat_col_next;
   logic [DF_W-1:0]   data_flow_reg, data_flow_next;
   logic              busy_reg, busy_next;
   logic              err_reg, err_next;
   logic [1:0]        err_code_reg, err_code_next;

   logic              rx_valid;
   logic              is_digit;
   logic              is_sep;
   logic [3:0]        digit;
   logic [MUL_W-1:0]  acc_calc;
   logic [ACC_W-1:0]  acc_sat;
   logic              dim_ok;
   logic [CNT_W-1:0]  total_slots;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DF_W-1:0]   stage_fill;
   logic              err_hit;
   logic [1:0]        err_sel;

   assign rx_valid    = bus.uart_rx_done & bus.en;
   assign is_digit    = (bus.uart_rx_data >= 8'h30) && (bus.uart_rx_data <= 8'h39);
   assign is_sep      = (bus.uart_rx_data == 8'h20) || (bus.uart_rx_data == 8'h0D) ||
                        (bus.uart_rx_data == 8'h0A);
   assign digit       = bus.uart_rx_data[3:0];
   assign acc_calc    = MUL_W'(acc_reg) * MUL_W'(10) + MUL_W'(digit);
   assign acc_sat     = (acc_calc > MUL_W'(ACC_MAX)) ? ACC_MAX : acc_calc[ACC_W-1:0];
   assign dim_ok      = (acc_reg != '0) && (acc_reg <= DIM_MAX);
   assign total_slots = CNT_W'(rows_reg) * CNT_W'(cols_reg);
   assign cnt_inc     = cnt_reg + CNT_W'(1);

   // Staging buffer with the just-terminated element merged in, so a commit captures it directly.
   genvar gi;
   generate
      for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
         assign stage_fill[gi*ELEM_W +: ELEM_W] = (cnt_reg == CNT_W'(gi)) ?
                                                  acc_reg[ELEM_W-1:0] :
                                                  stage_reg[gi*ELEM_W +: ELEM_W];
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      pend_next      = pend_reg;
      rows_next      = rows_reg;
      cols_next      = cols_reg;
      cnt_next       = cnt_reg;
      stage_next     = stage_reg;
      write_en_next  = 1'b0;
      mat_row_next   = mat_row_reg;
      mat_col_next   = mat_col_reg;
      data_flow_next = data_flow_reg;
      busy_next      = busy_reg;
      err_next       = 1'b0;
      err_code_next  = err_code_reg;
      err_hit        = 1'b0;
      err_sel        = 2'd0;

      if (!bus.en) begin
         // Leaving input mode drops any partial matrix silently; committed outputs stay.
         state_next = ST_IDLE;
         acc_next   = '0;
         pend_next  = 1'b0;
         cnt_next   = '0;
         busy_next  = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = ST_GET_ROW;
            ST_ERR_SYNC: begin
               if (rx_valid && (bus.uart_rx_data == 8'h0A)) state_next = ST_GET_ROW;
            end
            default: begin
               if (rx_valid) begin
                  if (is_digit) begin
                     acc_next  = acc_sat;
                     pend_next = 1'b1;
                     if (state_reg == ST_GET_ROW) busy_next = 1'b1;
                  end else if (is_sep) begin
                     if (pend_reg) begin
                        acc_next  = '0;
                        pend_next = 1'b0;
                        case (state_reg)
                           ST_GET_ROW: begin
                              if (dim_ok) begin
                                 rows_next  = acc_reg[2:0];
                                 state_next = ST_GET_COL;
                              end else begin
                                 err_hit = 1'b1;
                                 err_sel = 2'd2;
                              end
                           end
                           ST_GET_COL: begin
                              if (dim_ok) begin
                                 cols_next  = acc_reg[2:0];
                                 cnt_next   = '0;
                                 stage_next = '0;
                                 state_next = ST_GET_ELEM;
                              end else begin
                                 err_hit = 1'b1;
                                 err_sel = 2'd2;
                              end
                           end
                           ST_GET_ELEM: begin
                              if (acc_reg > ELEM_MAX) begin
                                 err_hit = 1'b1;
                                 err_sel = 2'd3;
                              end else if (cnt_inc == total_slots) begin
                                 write_en_next  = 1'b1;
                                 mat_row_next   = rows_reg;
                                 mat_col_next   = cols_reg;
                                 data_flow_next = stage_fill;
                                 cnt_next       = '0;
                                 busy_next      = 1'b0;
                                 state_next     = ST_GET_ROW;
                              end else begin
                                 stage_next = stage_fill;
                                 cnt_next   = cnt_inc;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end else begin
                     err_hit = 1'b1;
                     err_sel = 2'd1;
                  end
               end
            end
         endcase

         if (err_hit) begin
            err_next      = 1'b1;
            err_code_next = err_sel;
            state_next    = ST_ERR_SYNC;
            busy_next     = 1'b0;
            acc_next      = '0;
            pend_next     = 1'b0;
            cnt_next      = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         pend_reg      <= 1'b0;
         rows_reg      <= '0;
         cols_reg      <= '0;
         cnt_reg       <= '0;
         stage_reg     <= '0;
         write_en_reg  <= 1'b0;
         mat_row_reg   <= '0;
         mat_col_reg   <= '0;
         data_flow_reg <= '0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         err_code_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         pend_reg      <= pend_next;
         rows_reg      <= rows_next;
         cols_reg      <= cols_next;
         cnt_reg       <= cnt_next;
         stage_reg     <= stage_next;
         write_en_reg  <= write_en_next;
         mat_row_reg   <= mat_row_next;
         mat_col_reg   <= mat_col_next;
         data_flow_reg <= data_flow_next;
         busy_reg      <= busy_next;
         err_reg       <= err_next;
         err_code_reg  <= err_code_next;
      end
   end

   assign bus.write_en  = write_en_reg;
   assign bus.mat_row   = mat_row_reg;
   assign bus.mat_col   = mat_col_reg;
   assign bus.data_flow = data_flow_reg;
   assign bus.busy      = busy_reg;
   assign bus.err       = err_reg;
   assign bus.err_code  = err_code_reg;
endmodule
